// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage.
// Pipelined multiplier, 32-step restoring divider, stall and HI/LO write.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   start, op    EX request: 001 MULT, 010 MULTU, 011 DIV, 100 DIVU
//   opa, opb     rs / rt operands
//   flush        cancel the in-flight op
//   busy         sequencer not idle
//   stallreq     freeze PC/IF/ID/EX this cycle
//   done         one-cycle result strobe (whilo_o mirrors it)
//   hi_o, lo_o   remainder/quotient or product high/low
//   div_by_zero  qualifies done for a divide with opb == 0
module mdu_seq_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             flush,
  output logic             busy,
  output logic             stallreq,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             whilo_o,
  output logic             div_by_zero
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;

  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  // The HI/LO register is the last multiplier stage, so only
  // MUL_LAT-1 intermediate product registers are needed.
  localparam int MPN = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int MPI = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_dbz;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sgn;

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;
  logic             r_negq;
  logic             r_negr;

  logic [2*WIDTH-1:0] r_mp [MPN];

  logic w_is_mul;
  logic w_is_div;
  logic w_valid;
  logic w_accept;
  logic w_opb_zero;
  logic w_div_sgn;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;

  logic [2*WIDTH-1:0] w_ma;
  logic [2*WIDTH-1:0] w_mb;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mres;

  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_n;
  logic [WIDTH-1:0] w_quo_n;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  // Request decode
  assign w_is_mul   = (op == OP_MULT) | (op == OP_MULTU);
  assign w_is_div   = (op == OP_DIV) | (op == OP_DIVU);
  assign w_valid    = w_is_mul | w_is_div;
  assign w_opb_zero = (opb == '0);
  assign w_div_sgn  = (op == OP_DIV);
  assign w_accept   = (r_state == S_IDLE) & start
                    & w_valid & !flush;

  assign w_abs_a = (w_div_sgn & opa[WIDTH-1]) ? -opa : opa;
  assign w_abs_b = (w_div_sgn & opb[WIDTH-1]) ? -opb : opb;

  // Outputs
  assign busy        = (r_state != S_IDLE);
  assign stallreq    = !rst & start & w_valid
                     & (r_state != S_DONE) & !flush;
  assign done        = (r_state == S_DONE) & !flush;
  assign whilo_o     = done;
  assign div_by_zero = done & r_dbz;
  assign hi_o        = r_hi;
  assign lo_o        = r_lo;

  // Multiplier: sign/zero extend to 2*WIDTH, keep low 2*WIDTH bits
  assign w_ma = r_sgn ? {{WIDTH{r_a[WIDTH-1]}}, r_a}
                      : {{WIDTH{1'b0}}, r_a};
  assign w_mb = r_sgn ? {{WIDTH{r_b[WIDTH-1]}}, r_b}
                      : {{WIDTH{1'b0}}, r_b};
  assign w_prod = w_ma * w_mb;
  assign w_mres = (MUL_LAT == 1) ? w_prod : r_mp[MPI];

  always_ff @(posedge clk) begin
    r_mp[0] <= w_prod;
    for (int k = 1; k < MPN; k++) begin
      r_mp[k] <= r_mp[k-1];
    end
  end

  // Restoring divide step. Remainder stays below the divisor,
  // so the difference always fits in WIDTH bits.
  assign w_sh    = {r_rem, r_quo[WIDTH-1]};
  assign w_ge    = (w_sh >= {1'b0, r_dvs});
  assign w_rem_n = w_ge ? (w_sh[WIDTH-1:0] - r_dvs)
                        : w_sh[WIDTH-1:0];
  assign w_quo_n = {r_quo[WIDTH-2:0], w_ge};
  assign w_q_fix = r_negq ? -w_quo_n : w_quo_n;
  assign w_r_fix = r_negr ? -w_rem_n : w_rem_n;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mul) begin
              w_next = S_MUL;
            end else if (w_opb_zero) begin
              w_next = S_DONE;
            end else begin
              w_next = S_DIV;
            end
          end
        end
        S_MUL: begin
          if (r_cnt == MUL_LAST) begin
            w_next = S_DONE;
          end
        end
        S_DIV: begin
          if (r_cnt == DIV_LAST) begin
            w_next = S_DONE;
          end
        end
        S_DONE: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // Datapath; HI/LO only load on the edge that enters DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_dbz  <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_sgn  <= 1'b0;
      r_quo  <= '0;
      r_rem  <= '0;
      r_dvs  <= '0;
      r_negq <= 1'b0;
      r_negr <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_a    <= opa;
      r_b    <= opb;
      r_sgn  <= (op == OP_MULT);
      r_quo  <= w_abs_a;
      r_dvs  <= w_abs_b;
      r_rem  <= '0;
      r_negq <= w_div_sgn & (opa[WIDTH-1] ^ opb[WIDTH-1]);
      r_negr <= w_div_sgn & opa[WIDTH-1];
      r_dbz  <= 1'b0;
      if (w_is_div & w_opb_zero) begin
        r_hi  <= opa;
        r_lo  <= '1;
        r_dbz <= 1'b1;
      end
    end else if (!flush) begin
      unique case (r_state)
        S_MUL: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == MUL_LAST) begin
            r_hi <= w_mres[2*WIDTH-1:WIDTH];
            r_lo <= w_mres[WIDTH-1:0];
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          r_quo <= w_quo_n;
          r_rem <= w_rem_n;
          if (r_cnt == DIV_LAST) begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
          end
        end
        S_IDLE: begin
          r_dbz <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed testbench for mdu_seq_ctrl.
// Inputs change on the falling edge; outputs sampled 1ns later.
module tb_mdu_seq_ctrl;

  localparam int W = 32;

  localparam logic [2:0] MULT  = 3'b001;
  localparam logic [2:0] MULTU = 3'b010;
  localparam logic [2:0] DIV   = 3'b011;
  localparam logic [2:0] DIVU  = 3'b100;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         flush;
  logic         busy;
  logic         stallreq;
  logic         done;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;
  logic         whilo_o;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_seq_ctrl #(
    .WIDTH  (W),
    .MUL_LAT(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .flush      (flush),
    .busy       (busy),
    .stallreq   (stallreq),
    .done       (done),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o),
    .div_by_zero(div_by_zero)
  );

  task automatic drive(input logic s, input logic [2:0] o,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic f);
    start = s;
    op    = o;
    opa   = a;
    opb   = b;
    flush = f;
  endtask

  // Issue an op and hold it until done; lat = cycles from accept,
  // or -1 if done never arrived within the budget.
  task automatic run_to_done(input logic [2:0] o, input logic [W-1:0] a,
                             input logic [W-1:0] b, output int lat);
    lat = -1;
    @(negedge clk);
    drive(1'b1, o, a, b, 1'b0);
    for (int i = 0; i < 100; i++) begin
      #1;
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    drive(1'b1, MULT, 32'd3, 32'd4, 1'b0);
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL rst_stall got %b want 0", stallreq);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || whilo_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_ctl got busy=%b done=%b whilo=%b want 0",
               busy, done, whilo_o);
    end
    checks++;
    if (hi_o !== '0 || lo_o !== '0 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL rst_data got hi=%h lo=%h dbz=%b want 0",
               hi_o, lo_o, div_by_zero);
    end
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_div_signed();
    int sbad;
    int lat;
    sbad = 0;
    @(negedge clk);
    drive(1'b1, DIV, 32'd7, 32'hFFFF_FFFE, 1'b0);
    for (int k = 0; k <= 32; k++) begin
      #1;
      if (stallreq !== 1'b1 || done !== 1'b0) sbad++;
      @(negedge clk);
    end
    #1;
    checks++;
    if (sbad != 0) begin
      errors++; $display("FAIL div_stall got %0d bad cycles want 0", sbad);
    end
    checks++;
    if (done !== 1'b1 || whilo_o !== 1'b1 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL div_done got done=%b whilo=%b stall=%b want 1 1 0",
               done, whilo_o, stallreq);
    end
    checks++;
    if (lo_o !== 32'hFFFF_FFFD || hi_o !== 32'd1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL div_7_m2 got hi=%h lo=%h dbz=%b want 1 fffffffd 0",
               hi_o, lo_o, div_by_zero);
    end
    go_idle();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || lo_o !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_hold got done=%b busy=%b lo=%h want 0 0 fffffffd",
               done, busy, lo_o);
    end
    run_to_done(DIV, 32'hFFFF_FFF9, 32'd2, lat);
    checks++;
    if (lat !== 33 || lo_o !== 32'hFFFF_FFFD || hi_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL div_m7_2 got lat=%0d hi=%h lo=%h want 33 ffffffff fffffffd",
               lat, hi_o, lo_o);
    end
    go_idle();
  endtask

  task automatic test_div_unsigned();
    int lat;
    run_to_done(DIVU, 32'hFFFF_FFFF, 32'h10, lat);
    checks++;
    if (lat !== 33 || lo_o !== 32'h0FFF_FFFF || hi_o !== 32'hF) begin
      errors++;
      $display("FAIL divu got lat=%0d hi=%h lo=%h want 33 f 0fffffff",
               lat, hi_o, lo_o);
    end
    go_idle();
    run_to_done(DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 33 || lo_o !== 32'h8000_0000 || hi_o !== 32'h0) begin
      errors++;
      $display("FAIL div_ovf got lat=%0d hi=%h lo=%h want 33 0 80000000",
               lat, hi_o, lo_o);
    end
    go_idle();
  endtask

  task automatic test_mult();
    int lat;
    run_to_done(MULT, 32'hFFFF_FFFD, 32'd5, lat);
    checks++;
    if (lat !== 3 || hi_o !== 32'hFFFF_FFFF || lo_o !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL mult_m3_5 got lat=%0d hi=%h lo=%h want 3 ffffffff fffffff1",
               lat, hi_o, lo_o);
    end
    go_idle();
    run_to_done(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (lat !== 3 || hi_o !== 32'hFFFF_FFFE || lo_o !== 32'h1) begin
      errors++;
      $display("FAIL multu_max got lat=%0d hi=%h lo=%h want 3 fffffffe 1",
               lat, hi_o, lo_o);
    end
    go_idle();
    run_to_done(MULTU, 32'hFFFF_FFFD, 32'd5, lat);
    checks++;
    if (hi_o !== 32'h4 || lo_o !== 32'hFFFF_FFF1) begin
      errors++;
      $display("FAIL multu_fd_5 got hi=%h lo=%h want 4 fffffff1", hi_o, lo_o);
    end
    go_idle();
    run_to_done(MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, lat);
    checks++;
    if (hi_o !== 32'h0 || lo_o !== 32'h6) begin
      errors++;
      $display("FAIL mult_m2_m3 got hi=%h lo=%h want 0 6", hi_o, lo_o);
    end
    go_idle();
  endtask

  task automatic test_div_zero();
    int lat;
    run_to_done(DIV, 32'h1234, 32'h0, lat);
    checks++;
    if (lat !== 1 || div_by_zero !== 1'b1 || whilo_o !== 1'b1) begin
      errors++;
      $display("FAIL dbz_flag got lat=%0d dbz=%b whilo=%b want 1 1 1",
               lat, div_by_zero, whilo_o);
    end
    checks++;
    if (hi_o !== 32'h1234 || lo_o !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL dbz_data got hi=%h lo=%h want 1234 ffffffff", hi_o, lo_o);
    end
    go_idle();
    checks++;
    if (div_by_zero !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL dbz_clear got dbz=%b done=%b want 0 0", div_by_zero, done);
    end
  endtask

  task automatic test_flush();
    int lat;
    int dbad;
    dbad = 0;
    run_to_done(MULTU, 32'd3, 32'd4, lat);
    go_idle();
    @(negedge clk);
    drive(1'b1, DIVU, 32'd1000, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    checks++;
    if (stallreq !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL flush_now got stall=%b done=%b want 0 0", stallreq, done);
    end
    go_idle();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL flush_idle got busy=%b want 0", busy);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) dbad++;
    end
    checks++;
    if (dbad != 0 || hi_o !== 32'h0 || lo_o !== 32'd12) begin
      errors++;
      $display("FAIL flush_quiet got bad=%0d hi=%h lo=%h want 0 0 c",
               dbad, hi_o, lo_o);
    end
    run_to_done(DIVU, 32'd100, 32'd7, lat);
    checks++;
    if (lat !== 33 || lo_o !== 32'd14 || hi_o !== 32'd2) begin
      errors++;
      $display("FAIL flush_after got lat=%0d hi=%h lo=%h want 33 2 e",
               lat, hi_o, lo_o);
    end
    go_idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive(1'b1, DIVU, 32'hDEAD_BEEF, 32'd9, 1'b0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL rstmid_stall got %b want 0", stallreq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi_o !== '0 || lo_o !== '0) begin
      errors++;
      $display("FAIL rstmid got busy=%b done=%b hi=%h lo=%h want 0 0 0 0",
               busy, done, hi_o, lo_o);
    end
    drive(1'b0, 3'b000, '0, '0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_invalid_op();
    int bad;
    bad = 0;
    @(negedge clk);
    drive(1'b1, 3'b000, 32'd5, 32'd6, 1'b0);
    #1;
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL inv_stall got %b want 0", stallreq);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      op = (k < 2) ? 3'b000 : 3'b101;
      #1;
      if (busy !== 1'b0 || done !== 1'b0 || stallreq !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL inv_quiet got %0d bad cycles want 0", bad);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    int lat1;
    int lat2;
    run_to_done(MULT, 32'd2, 32'd3, lat1);
    checks++;
    if (lat1 !== 3 || lo_o !== 32'd6) begin
      errors++;
      $display("FAIL b2b_first got lat=%0d lo=%h want 3 6", lat1, lo_o);
    end
    run_to_done(MULTU, 32'd7, 32'd9, lat2);
    checks++;
    if (lat2 !== 3 || lo_o !== 32'd63 || hi_o !== 32'd0) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d hi=%h lo=%h want 3 0 3f",
               lat2, hi_o, lo_o);
    end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_div_signed();
    test_div_unsigned();
    test_mult();
    test_div_zero();
    test_flush();
    test_reset_mid();
    test_invalid_op();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
